multicycle_ctrl: RTL
====================

# multicycle_ctrl

Parametrised multicycle control FSM for the MIPS-subset datapath, successor to the fixed-latency control unit. It sequences fetch, decode, execute and write-back per instruction and drives every datapath mux and write-enable. New relative to the previous generation:
- configurable memory read latency;
- beq/bne branches;
- overflow and illegal-opcode exceptions with EPC capture and vectored handler entry;
- no dead wait state between instructions.

## Interface
Parameters:
- MEM_LAT, 2: memory read latency in cycles, legal range 1..7.
- EXC_ENABLE, 1: 1 enables overflow and illegal-opcode exceptions; 0 treats overflow as ignored and illegal opcodes as no-ops.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- OpCode  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Overflow  in  1  ALU overflow for the current cycle.
- Zero  in  1  ALU result equals zero for the current cycle.
- ALUSrcA  out 2, ALUSrcB  out 3, ALUOp  out 3, PCSource  out 3: datapath mux selects and ALU function (1 add, 2 sub, 3 and).
- PCWrite, MemWr, IRWrite, WriteRegA, WriteRegB, ALUOutControl, RegWrite, EPCWrite  out 1 each: register and memory write enables.
- Iord  out 3, MemToReg  out 4, RegDst  out 2: address, write-data and destination selects.
- ShiftControl  out 3, ShiftSrc  out 1, ShiftAmt  out 1: shifter controls.
- ExcCause  out 2: 0 none, 1 illegal opcode, 2 overflow; held until the next FETCH.
- StateOut  out 7: current state encoding.

## Operation
- Outputs are combinational (Moore) from the state, except the branch PCWrite term. Any output not listed for a state is 0.
- One cycle counter `cnt`, 3 bits, used by MEMWAIT and EXCWAIT.

States (StateOut value) and outputs:
- RESET (1): RegDst=1, MemToReg=8, RegWrite=1 (initialise $sp). Next: FETCH.
- FETCH (2): ALUSrcB=1, ALUOp=1, PCWrite=1, Iord=0 (PC←PC+4). Loads cnt=MEM_LAT. Next: MEMWAIT.
- MEMWAIT (3): decrements cnt. IRWrite=1 when cnt==1, and the state then moves to DECODE.
- DECODE (4): WriteRegA=WriteRegB=1. Precomputes the branch target: ALUSrcB=3, ALUOp=1, ALUOutControl=1.
- DECODE dispatch:
  - OpCode 0 with Funct 0x20 → ADD; 0x22 → SUB; 0x24 → AND; 0x00 → SLL; 0x04 → SLLV; 0x08 → JR; 0x0D → BREAK; 0x13 → RTE.
  - OpCode 0x08 → ADDI; 0x04 → BEQ; 0x05 → BNE.
  - Anything else → EXC with cause 1, or FETCH when EXC_ENABLE=0.
- ADD/SUB/AND (5/6/7): ALUSrcA=2, ALUOp=1/2/3, ALUOutControl=1. Next: WBR, or EXC with cause 2 if ADD/SUB and Overflow=1 and EXC_ENABLE=1.
- ADDI (8): ALUSrcA=2, ALUSrcB=2, ALUOp=1, ALUOutControl=1. Next: WBI, with the same overflow rule as ADD/SUB.
- WBR (9): RegDst=3, RegWrite=1. WBI (10): RegDst=0, RegWrite=1. Both → FETCH.
- SLL/SLLV (11/12): ShiftControl=1 (load), WriteRegB=1. ShiftSrc=ShiftAmt=1 for SLL, 0 for SLLV. Next: SHIFT.
- SHIFT (13): ShiftControl=2, shift-source bits held. Next: SHWB.
- SHWB (14): MemToReg=4, RegDst=3, RegWrite=1, shift-source bits held. Next: FETCH.
- BEQ/BNE (15/16): ALUSrcA=2, ALUOp=2, PCSource=1. PCWrite = Zero for BEQ, !Zero for BNE. Next: FETCH.
- JR (17): PCSource=4, PCWrite=1. RTE (18): PCSource=3, PCWrite=1. Both → FETCH.
- BREAK (19): ALUSrcB=1, ALUOp=2, PCWrite=1 (PC←PC−4, so the instruction re-executes and the core halts). Next: FETCH.
- EXC (20): ALUSrcB=1, ALUOp=2, EPCWrite=1 (EPC←PC−4). Iord=3 for cause 1, 4 for cause 2. Loads cnt=MEM_LAT. Next: EXCWAIT.
- EXCWAIT (21): Iord held, cnt decrements. At cnt==1 → EXCLOAD.
- EXCLOAD (22): PCSource=2 (vector byte from memory), PCWrite=1. Next: FETCH.

## Timing
- reset low forces state=RESET and cnt=0 immediately, from any state including MEMWAIT or EXCWAIT. Every output takes its RESET value while reset is low.
- The first rising edge with reset high moves the FSM to FETCH.
- Latency from FETCH entry to the next FETCH:
  - ALU R-type and ADDI: MEM_LAT+4.
  - SLL/SLLV: MEM_LAT+5.
  - BEQ/BNE, JR, RTE, BREAK: MEM_LAT+3.
  - Exception: MEM_LAT+2 to reach EXC, then MEM_LAT+2 more to return to FETCH.
- IRWrite is high for exactly one cycle per instruction.
- Overflow is sampled in the execute cycle only. On overflow, RegWrite never asserts for that instruction.
- ExcCause is set on entry to EXC and cleared on entry to FETCH.

## Test plan
- reset low for 3 cycles, then high → StateOut=1 during reset; RegWrite=1 and RegDst=1; StateOut=2 on the first edge after release.
- ADD with MEM_LAT=2 → IRWrite pulses at cycle 3; RegWrite=1 with RegDst=3 at cycle 6; FETCH again at cycle 7. Repeat with MEM_LAT=5 → RegWrite at cycle 9.
- BEQ with Zero=1 → PCWrite=1 with PCSource=1. BNE with Zero=1 → PCWrite=0. Both reach FETCH after MEM_LAT+3 cycles.
- ADDI with Overflow=1 in the execute cycle → EPCWrite=1, Iord=4, ExcCause=2, RegWrite never asserted; EXCLOAD asserts PCWrite with PCSource=2.
- OpCode 0x3F → ExcCause=1, Iord=3. The same stimulus with EXC_ENABLE=0 → FETCH directly from DECODE.
- reset pulsed low during MEMWAIT → StateOut=1 asynchronously and IRWrite=0; normal fetch resumes after release.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the multicycle control FSM and the MIPS-subset datapath.
//   Datapath -> control : OpCode[5:0], Funct[5:0], Overflow, Zero
//   Control -> datapath : ALU/PC mux selects (ALUSrcA, ALUSrcB, ALUOp, PCSource),
//                         write enables (PCWrite, MemWr, IRWrite, WriteRegA,
//                         WriteRegB, ALUOutControl, RegWrite, EPCWrite),
//                         address/write-data/destination selects (Iord,
//                         MemToReg, RegDst), shifter controls (ShiftControl,
//                         ShiftSrc, ShiftAmt), ExcCause and StateOut.
// master = control unit, slave = datapath.
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       Overflow;
    logic       Zero;
    logic [1:0] ALUSrcA;
    logic [2:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [2:0] PCSource;
    logic       PCWrite;
    logic       MemWr;
    logic       IRWrite;
    logic       WriteRegA;
    logic       WriteRegB;
    logic       ALUOutControl;
    logic       RegWrite;
    logic       EPCWrite;
    logic [2:0] Iord;
    logic [3:0] MemToReg;
    logic [1:0] RegDst;
    logic [2:0] ShiftControl;
    logic       ShiftSrc;
    logic       ShiftAmt;
    logic [1:0] ExcCause;
    logic [6:0] StateOut;

    modport master (
        input  OpCode, Funct, Overflow, Zero,
        output ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, MemWr, IRWrite,
               WriteRegA, WriteRegB, ALUOutControl, RegWrite, EPCWrite,
               Iord, MemToReg, RegDst, ShiftControl, ShiftSrc, ShiftAmt,
               ExcCause, StateOut
    );

    modport slave (
        output OpCode, Funct, Overflow, Zero,
        input  ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, MemWr, IRWrite,
               WriteRegA, WriteRegB, ALUOutControl, RegWrite, EPCWrite,
               Iord, MemToReg, RegDst, ShiftControl, ShiftSrc, ShiftAmt,
               ExcCause, StateOut
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multicycle control FSM for the MIPS-subset datapath: fetch, memory wait,
// decode, execute and write-back per instruction, with beq/bne, shifts, jr,
// rte, break, and overflow / illegal-opcode exceptions with vectored entry.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-low; forces RESET state and its outputs
//   bus    - multicycle_ctrl_if.master (instruction fields, ALU flags in;
//            every datapath select / write enable, ExcCause, StateOut out)
// Parameters:
//   MEM_LAT    - memory read latency in cycles (1..7)
//   EXC_ENABLE - 1 enables overflow / illegal-opcode exceptions
// The control word is registered from the next state, so each output equals
// the Moore value of the current state. Only the branch PCWrite term is
// combinational, because it depends on this cycle's Zero flag.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_LAT    = 2,
    parameter int EXC_ENABLE = 1
) (
    input  logic              clock,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [6:0] {
        ST_RESET   = 7'd1,  ST_FETCH   = 7'd2,  ST_MEMWAIT = 7'd3,
        ST_DECODE  = 7'd4,  ST_ADD     = 7'd5,  ST_SUB     = 7'd6,
        ST_AND     = 7'd7,  ST_ADDI    = 7'd8,  ST_WBR     = 7'd9,
        ST_WBI     = 7'd10, ST_SLL     = 7'd11, ST_SLLV    = 7'd12,
        ST_SHIFT   = 7'd13, ST_SHWB    = 7'd14, ST_BEQ     = 7'd15,
        ST_BNE     = 7'd16, ST_JR      = 7'd17, ST_RTE     = 7'd18,
        ST_BREAK   = 7'd19, ST_EXC     = 7'd20, ST_EXCWAIT = 7'd21,
        ST_EXCLOAD = 7'd22
    } state_t;

    typedef struct packed {
        logic [1:0] alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
        logic [2:0] pc_source;
        logic       pc_write;
        logic       mem_wr;
        logic       ir_write;
        logic       write_reg_a;
        logic       write_reg_b;
        logic       alu_out_control;
        logic       reg_write;
        logic       epc_write;
        logic [2:0] iord;
        logic [3:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic [2:0] shift_control;
        logic       shift_src;
        logic       shift_amt;
    } ctrl_t;

    localparam logic [2:0] LAT_C      = 3'(MEM_LAT);
    localparam logic       EXC_ON     = (EXC_ENABLE != 0);
    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_ILL  = 2'd1;
    localparam logic [1:0] CAUSE_OVF  = 2'd2;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] cnt_r;
    logic [2:0] cnt_nxt_s;
    logic [1:0] cause_r;
    logic [1:0] cause_nxt_s;
    logic       is_sll_r;
    logic       is_sll_nxt_s;
    ctrl_t      ctrl_r;
    ctrl_t      ctrl_nxt_s;
    logic       branch_take_s;

    // Instruction dispatch; ST_EXC stands for "not a supported instruction".
    function automatic state_t dispatch_f(input logic [5:0] op, input logic [5:0] fn);
        state_t st;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20:   st = ST_ADD;
                    6'h22:   st = ST_SUB;
                    6'h24:   st = ST_AND;
                    6'h00:   st = ST_SLL;
                    6'h04:   st = ST_SLLV;
                    6'h08:   st = ST_JR;
                    6'h0D:   st = ST_BREAK;
                    6'h13:   st = ST_RTE;
                    default: st = ST_EXC;
                endcase
            end
            6'h08:   st = ST_ADDI;
            6'h04:   st = ST_BEQ;
            6'h05:   st = ST_BNE;
            default: st = ST_EXC;
        endcase
        return st;
    endfunction

    // Moore control word for a state; cnt/cause/is_sll are the values held in that state.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [2:0] cnt,
                                       input logic [1:0] cause, input logic is_sll);
        ctrl_t c;
        c = '0;
        case (st)
            ST_RESET: begin
                c.reg_dst    = 2'd1;
                c.mem_to_reg = 4'd8;
                c.reg_write  = 1'b1;
            end
            ST_FETCH: begin
                c.alu_src_b = 3'd1;
                c.alu_op    = 3'd1;
                c.pc_write  = 1'b1;
            end
            ST_MEMWAIT: c.ir_write = (cnt == 3'd1);
            ST_DECODE: begin
                c.write_reg_a     = 1'b1;
                c.write_reg_b     = 1'b1;
                c.alu_src_b       = 3'd3;
                c.alu_op          = 3'd1;
                c.alu_out_control = 1'b1;
            end
            ST_ADD, ST_SUB, ST_AND: begin
                c.alu_src_a       = 2'd2;
                c.alu_op          = (st == ST_ADD) ? 3'd1 : ((st == ST_SUB) ? 3'd2 : 3'd3);
                c.alu_out_control = 1'b1;
            end
            ST_ADDI: begin
                c.alu_src_a       = 2'd2;
                c.alu_src_b       = 3'd2;
                c.alu_op          = 3'd1;
                c.alu_out_control = 1'b1;
            end
            ST_WBR: begin
                c.reg_dst   = 2'd3;
                c.reg_write = 1'b1;
            end
            ST_WBI: c.reg_write = 1'b1;
            ST_SLL, ST_SLLV: begin
                c.shift_control = 3'd1;
                c.write_reg_b   = 1'b1;
                c.shift_src     = is_sll;
                c.shift_amt     = is_sll;
            end
            ST_SHIFT: begin
                c.shift_control = 3'd2;
                c.shift_src     = is_sll;
                c.shift_amt     = is_sll;
            end
            ST_SHWB: begin
                c.mem_to_reg = 4'd4;
                c.reg_dst    = 2'd3;
                c.reg_write  = 1'b1;
                c.shift_src  = is_sll;
                c.shift_amt  = is_sll;
            end
            ST_BEQ, ST_BNE: begin
                c.alu_src_a = 2'd2;
                c.alu_op    = 3'd2;
                c.pc_source = 3'd1;
            end
            ST_JR: begin
                c.pc_source = 3'd4;
                c.pc_write  = 1'b1;
            end
            ST_RTE: begin
                c.pc_source = 3'd3;
                c.pc_write  = 1'b1;
            end
            ST_BREAK: begin
                c.alu_src_b = 3'd1;
                c.alu_op    = 3'd2;
                c.pc_write  = 1'b1;
            end
            ST_EXC: begin
                c.alu_src_b = 3'd1;
                c.alu_op    = 3'd2;
                c.epc_write = 1'b1;
                c.iord      = (cause == CAUSE_OVF) ? 3'd4 : 3'd3;
            end
            ST_EXCWAIT: c.iord = (cause == CAUSE_OVF) ? 3'd4 : 3'd3;
            ST_EXCLOAD: begin
                c.pc_source = 3'd2;
                c.pc_write  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state, counter, exception-cause and shift-source computation.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        cause_nxt_s  = cause_r;
        is_sll_nxt_s = is_sll_r;
        case (state_r)
            ST_RESET: state_nxt_s = ST_FETCH;
            ST_FETCH: begin
                state_nxt_s = ST_MEMWAIT;
                cnt_nxt_s   = LAT_C;
            end
            ST_MEMWAIT: begin
                cnt_nxt_s = cnt_r - 3'd1;
                // <= 1 rather than == 1 so a corrupted zero count cannot stall the core
                if (cnt_r <= 3'd1) begin
                    state_nxt_s = ST_DECODE;
                end else begin
                    state_nxt_s = ST_MEMWAIT;
                end
            end
            ST_DECODE: begin
                state_nxt_s  = dispatch_f(bus.OpCode, bus.Funct);
                is_sll_nxt_s = (state_nxt_s == ST_SLL);
                if (state_nxt_s != ST_EXC) begin
                    cause_nxt_s = cause_r;
                end else if (EXC_ON) begin
                    cause_nxt_s = CAUSE_ILL;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_ADD, ST_SUB, ST_ADDI: begin
                if (bus.Overflow && EXC_ON) begin
                    state_nxt_s = ST_EXC;
                    cause_nxt_s = CAUSE_OVF;
                end else begin
                    state_nxt_s = (state_r == ST_ADDI) ? ST_WBI : ST_WBR;
                end
            end
            ST_AND:           state_nxt_s = ST_WBR;
            ST_SLL, ST_SLLV:  state_nxt_s = ST_SHIFT;
            ST_SHIFT:         state_nxt_s = ST_SHWB;
            ST_EXC: begin
                state_nxt_s = ST_EXCWAIT;
                cnt_nxt_s   = LAT_C;
            end
            ST_EXCWAIT: begin
                cnt_nxt_s = cnt_r - 3'd1;
                if (cnt_r <= 3'd1) begin
                    state_nxt_s = ST_EXCLOAD;
                end else begin
                    state_nxt_s = ST_EXCWAIT;
                end
            end
            ST_WBR, ST_WBI, ST_SHWB, ST_BEQ, ST_BNE, ST_JR, ST_RTE, ST_BREAK, ST_EXCLOAD:
                state_nxt_s = ST_FETCH;
            default: state_nxt_s = ST_FETCH;
        endcase
        // the cause stays visible to the handler until the next instruction starts
        if (state_nxt_s == ST_FETCH) begin
            cause_nxt_s = CAUSE_NONE;
        end else begin
            cause_nxt_s = cause_nxt_s;
        end
        ctrl_nxt_s = ctrl_for(state_nxt_s, cnt_nxt_s, cause_nxt_s, is_sll_nxt_s);
    end

    // FSM state, counter and registered control word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_RESET;
            cnt_r    <= 3'd0;
            cause_r  <= CAUSE_NONE;
            is_sll_r <= 1'b0;
            ctrl_r   <= ctrl_for(ST_RESET, 3'd0, CAUSE_NONE, 1'b0);
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            cause_r  <= cause_nxt_s;
            is_sll_r <= is_sll_nxt_s;
            ctrl_r   <= ctrl_nxt_s;
        end
    end

    assign branch_take_s = ((state_r == ST_BEQ) &&  bus.Zero) ||
                           ((state_r == ST_BNE) && !bus.Zero);

    assign bus.ALUSrcA       = ctrl_r.alu_src_a;
    assign bus.ALUSrcB       = ctrl_r.alu_src_b;
    assign bus.ALUOp         = ctrl_r.alu_op;
    assign bus.PCSource      = ctrl_r.pc_source;
    assign bus.PCWrite       = ctrl_r.pc_write | branch_take_s;
    assign bus.MemWr         = ctrl_r.mem_wr;
    assign bus.IRWrite       = ctrl_r.ir_write;
    assign bus.WriteRegA     = ctrl_r.write_reg_a;
    assign bus.WriteRegB     = ctrl_r.write_reg_b;
    assign bus.ALUOutControl = ctrl_r.alu_out_control;
    assign bus.RegWrite      = ctrl_r.reg_write;
    assign bus.EPCWrite      = ctrl_r.epc_write;
    assign bus.Iord          = ctrl_r.iord;
    assign bus.MemToReg      = ctrl_r.mem_to_reg;
    assign bus.RegDst        = ctrl_r.reg_dst;
    assign bus.ShiftControl  = ctrl_r.shift_control;
    assign bus.ShiftSrc      = ctrl_r.shift_src;
    assign bus.ShiftAmt      = ctrl_r.shift_amt;
    assign bus.ExcCause      = cause_r;
    assign bus.StateOut      = state_r;
endmodule
